tx_ds_char: RTL and testbench

//  Character-level transmitter for the DS link, mirror of the character receiver. Accepts N-chars (8-bit data)
//  and L-chars (2-bit control code) and emits them as 2-bit pairs, LSB pair first, for the DS bit serializer.

---
 rtl/tx_ds_char_pkg.sv | 54 +++++
 rtl/tx_ds_char.sv | 152 +++++++++++++++
 tb/tb_tx_ds_char.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_ds_char_pkg.sv
// ---------------------------------------------------------------------------
// tx_ds_char_pkg
// Shared definitions for the DS-link character layer, used by the
// transmitter and by the matching character receiver:
//   state_t        one-hot character-sequencer states
//   LCODE_*        L-char control codes
//   *_CHAR_PAIRS   pairs on the wire per character type (ICT pair included)
//   pair_for()     the 2-bit pair a given state puts on the serializer
// No ports (package).
// ---------------------------------------------------------------------------
package tx_ds_char_pkg;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_SEND_ICT = 7'b000_0010,
    ST_SEND_P0  = 7'b000_0100,
    ST_SEND_P1  = 7'b000_1000,
    ST_SEND_P2  = 7'b001_0000,
    ST_SEND_P3  = 7'b010_0000,
    ST_SEND_CMD = 7'b100_0000
  } state_t;

  localparam logic [1:0] LCODE_FCT = 2'b00;
  localparam logic [1:0] LCODE_EOP = 2'b01;
  localparam logic [1:0] LCODE_EEP = 2'b10;
  localparam logic [1:0] LCODE_ESC = 2'b11;

  localparam int N_CHAR_PAIRS = 5;
  localparam int L_CHAR_PAIRS = 2;

  // Pair driven while sitting in state st. The ICT pair is {flag, p}; p is
  // chosen so that the previous character's bits, p and flag XOR to 1.
  // An L-char carries its code in data[1:0].
  function automatic logic [1:0] pair_for(
    input state_t     st,
    input logic       is_l,
    input logic [7:0] data,
    input logic [1:0] acc
  );
    logic [1:0] pair;
    pair = 2'b00;
    case (st)
      ST_SEND_ICT: pair = {is_l, ~(^acc ^ is_l)};
      ST_SEND_P0:  pair = data[1:0];
      ST_SEND_P1:  pair = data[3:2];
      ST_SEND_P2:  pair = data[5:4];
      ST_SEND_P3:  pair = data[7:6];
      ST_SEND_CMD: pair = data[1:0];
      default:     pair = 2'b00;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/tx_ds_char.sv
// ---------------------------------------------------------------------------
// tx_ds_char
// Character-level transmitter for the DS link. Takes N-chars (8-bit data)
// and L-chars (2-bit control code) from the link FSM / TX FIFO and hands
// them to the DS bit serializer as 2-bit pairs, LSB pair first, preceded by
// an ICT pair {flag, odd parity}.
//
// Ports
//   txClk      in   clock, all state on rising edge
//   txReset    in   synchronous active-high reset
//   charValid  in   upstream offers a character
//   charIsL    in   1 = L-char (code in charData[1:0]), 0 = N-char
//   charData   in   [7:0] N-char data / L-char code
//   charReady  out  character accepted when charValid && charReady
//   q          out  [1:0] pair to serializer, q[1] sent first
//   qValid     out  q holds a valid pair
//   qReady     in   serializer takes the pair when qValid && qReady
//   busy       out  a character is in flight
//
// State table
//   state        | meaning
//   ST_IDLE      | nothing in flight, ready for a character
//   ST_SEND_ICT  | offering {flag, parity} pair
//   ST_SEND_P0   | offering data[1:0]
//   ST_SEND_P1   | offering data[3:2]
//   ST_SEND_P2   | offering data[5:4]
//   ST_SEND_P3   | offering data[7:6], may accept the next character
//   ST_SEND_CMD  | offering L-char code, may accept the next character
// ---------------------------------------------------------------------------
module tx_ds_char
  import tx_ds_char_pkg::*;
(
  input  logic       txClk,
  input  logic       txReset,
  input  logic       charValid,
  input  logic       charIsL,
  input  logic [7:0] charData,
  output logic       charReady,
  output logic [1:0] q,
  output logic       qValid,
  input  logic       qReady,
  output logic       busy
);

  state_t     r_state;
  logic [1:0] r_acc;
  logic [7:0] r_data;
  logic       r_is_l;
  logic [1:0] r_q;
  logic       r_q_valid;
  logic       r_busy;

  state_t     w_state_nxt;
  logic [1:0] w_acc_nxt;
  logic [7:0] w_data_nxt;
  logic       w_is_l_nxt;
  logic       w_adv;
  logic       w_last;
  logic       w_char_ready;
  logic       w_accept;

  assign w_adv  = r_q_valid & qReady;
  assign w_last = (r_state == ST_SEND_P3) || (r_state == ST_SEND_CMD);

  // Ready in the last pair of a character only when that pair leaves this
  // cycle, so the next ICT follows with no idle gap.
  assign w_char_ready = ~txReset & ((r_state == ST_IDLE) | (w_last & qReady));
  assign w_accept     = charValid & w_char_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_data;
    w_is_l_nxt  = r_is_l;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt  = charData;
          w_is_l_nxt  = charIsL;
          w_state_nxt = ST_SEND_ICT;
        end
      end
      ST_SEND_ICT: begin
        if (w_adv) begin
          // Parity of the next character covers only this one's payload.
          w_acc_nxt   = 2'b00;
          w_state_nxt = r_is_l ? ST_SEND_CMD : ST_SEND_P0;
        end
      end
      ST_SEND_P0: begin
        if (w_adv) begin
          w_acc_nxt   = r_acc ^ r_q;
          w_state_nxt = ST_SEND_P1;
        end
      end
      ST_SEND_P1: begin
        if (w_adv) begin
          w_acc_nxt   = r_acc ^ r_q;
          w_state_nxt = ST_SEND_P2;
        end
      end
      ST_SEND_P2: begin
        if (w_adv) begin
          w_acc_nxt   = r_acc ^ r_q;
          w_state_nxt = ST_SEND_P3;
        end
      end
      ST_SEND_P3, ST_SEND_CMD: begin
        if (w_adv) begin
          w_acc_nxt   = r_acc ^ r_q;
          w_state_nxt = ST_IDLE;
          if (w_accept) begin
            w_data_nxt  = charData;
            w_is_l_nxt  = charIsL;
            w_state_nxt = ST_SEND_ICT;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // q is computed from the next-state values so it is a flop output and
  // stays put while the serializer stalls.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      r_state   <= ST_IDLE;
      r_acc     <= 2'b00;
      r_data    <= 8'h00;
      r_is_l    <= 1'b0;
      r_q       <= 2'b00;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_data    <= w_data_nxt;
      r_is_l    <= w_is_l_nxt;
      r_q       <= pair_for(w_state_nxt, w_is_l_nxt, w_data_nxt, w_acc_nxt);
      r_q_valid <= (w_state_nxt != ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign charReady = w_char_ready;
  assign q         = r_q;
  assign qValid    = r_q_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tx_ds_char.sv
// ---------------------------------------------------------------------------
// tb_tx_ds_char
// Self-checking bench for tx_ds_char. The reference model keeps a queue of
// the pairs still owed to the serializer and the 1-count of the previous
// character's payload; ready/valid/busy follow from the queue length.
// ---------------------------------------------------------------------------
module tb_tx_ds_char;

  logic       txClk = 1'b0;
  logic       txReset = 1'b1;
  logic       charValid = 1'b0;
  logic       charIsL = 1'b0;
  logic [7:0] charData = 8'h00;
  logic       charReady;
  logic [1:0] q;
  logic       qValid;
  logic       qReady = 1'b0;
  logic       busy;

  always #5 txClk = ~txClk;

  tx_ds_char dut (
    .txClk     (txClk),
    .txReset   (txReset),
    .charValid (charValid),
    .charIsL   (charIsL),
    .charData  (charData),
    .charReady (charReady),
    .q         (q),
    .qValid    (qValid),
    .qReady    (qReady),
    .busy      (busy)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         prev_ones = 0;
  bit         accepted = 1'b0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_log[$];
  int         adv_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected wire pairs of one character. p is picked so the total number of
  // ones over previous payload + flag + p is odd.
  function automatic void push_char(input logic is_l, input logic [7:0] d);
    int  ones;
    logic p;
    ones = prev_ones + (is_l ? 1 : 0);
    p = ((ones % 2) == 0);
    exp_q.push_back({is_l, p});
    if (is_l) begin
      exp_q.push_back(d[1:0]);
      prev_ones = $countones(d[1:0]);
    end else begin
      for (int k = 0; k < 4; k++) exp_q.push_back(d[2*k +: 2]);
      prev_ones = $countones(d);
    end
  endfunction

  // Check outputs at the falling edge, then advance the model for the
  // coming rising edge; inputs change only just after a rising edge.
  task automatic cycle();
    bit rdy;
    @(negedge txClk);
    cyc++;
    rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && qReady);
    chk("qValid", qValid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("q", q, exp_q[0]);
    chk("charReady", charReady, !txReset && rdy);
    if (txReset) begin
      exp_q.delete();
      prev_ones = 0;
    end else begin
      if (exp_q.size() != 0 && qReady) begin
        obs_log.push_back(q);
        adv_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (charValid && rdy) begin
        push_char(charIsL, charData);
        accepted = 1'b1;
      end
    end
    @(posedge txClk);
    #1;
  endtask

  task automatic send(input logic is_l, input logic [7:0] d);
    charValid = 1'b1;
    charIsL   = is_l;
    charData  = d;
    accepted  = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) cycle();
    if (!accepted) chk("accept_timeout", 0, 1);
    charValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    cycle();
  endtask

  task automatic wait_left(input int n);
    int i;
    for (i = 0; i < 100 && exp_q.size() != n; i++) cycle();
    if (exp_q.size() != n) chk("wait_timeout", exp_q.size(), n);
  endtask

  initial begin
    logic [1:0] ref_a5[5];
    logic [1:0] ref_l[2];
    logic [1:0] ref_00[5];
    logic [7:0] b2b[3];
    int sent;

    ref_a5[0] = 2'b01; ref_a5[1] = 2'b01; ref_a5[2] = 2'b01; ref_a5[3] = 2'b10; ref_a5[4] = 2'b10;
    ref_l[0]  = 2'b10; ref_l[1]  = 2'b00;
    ref_00[0] = 2'b01; ref_00[1] = 2'b00; ref_00[2] = 2'b00; ref_00[3] = 2'b00; ref_00[4] = 2'b00;

    // reset
    cycle();
    chk("reset_q", q, 2'b00);
    cycle();
    txReset = 1'b0;
    qReady  = 1'b1;
    cycle();

    // N-char 0xA5
    obs_log.delete();
    send(1'b0, 8'hA5);
    drain();
    chk("a5_len", obs_log.size(), 5);
    for (int i = 0; i < 5 && i < obs_log.size(); i++) chk("a5_pair", obs_log[i], ref_a5[i]);

    // L-char code 00; upper bits must be ignored
    obs_log.delete();
    send(1'b1, 8'hFC);
    drain();
    chk("l_len", obs_log.size(), 2);
    for (int i = 0; i < 2 && i < obs_log.size(); i++) chk("l_pair", obs_log[i], ref_l[i]);

    // N-char 0x00
    obs_log.delete();
    send(1'b0, 8'h00);
    drain();
    chk("n00_len", obs_log.size(), 5);
    for (int i = 0; i < 5 && i < obs_log.size(); i++) chk("n00_pair", obs_log[i], ref_00[i]);

    // stall five cycles while sending P1
    send(1'b0, 8'h3C);
    wait_left(3);
    qReady = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("stall_left", exp_q.size(), 3);
    qReady = 1'b1;
    drain();

    // back-to-back: three N-chars with charValid held high
    b2b[0] = 8'h5A; b2b[1] = 8'hFF; b2b[2] = 8'h81;
    adv_cyc.delete();
    charValid = 1'b1;
    charIsL   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      charData = b2b[k];
      accepted = 1'b0;
      for (int i = 0; i < 100 && !accepted; i++) cycle();
      if (!accepted) chk("b2b_accept_timeout", 0, 1);
    end
    charValid = 1'b0;
    drain();
    chk("b2b_pairs", adv_cyc.size(), 15);
    if (adv_cyc.size() == 15) chk("b2b_span", adv_cyc[14] - adv_cyc[0], 14);

    // reset while sending P2; next char's parity must start from zero
    send(1'b0, 8'h01);
    wait_left(2);
    txReset = 1'b1;
    cycle();
    txReset = 1'b0;
    cycle();
    chk("rst_mid_qvalid", qValid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    obs_log.delete();
    send(1'b0, 8'h00);
    drain();
    if (obs_log.size() != 0) chk("rst_mid_ict", obs_log[0], 2'b01);
    else chk("rst_mid_len", obs_log.size(), 5);

    // randomized traffic with serializer back-pressure
    sent = 0;
    for (int i = 0; i < 6000 && sent < 300; i++) begin
      if (!charValid && $urandom_range(0, 2) != 0) begin
        charValid = 1'b1;
        charIsL   = $urandom_range(0, 1);
        charData  = 8'($urandom);
      end
      qReady   = ($urandom_range(0, 3) != 0);
      accepted = 1'b0;
      cycle();
      if (accepted) begin
        sent++;
        charValid = 1'b0;
      end
    end
    charValid = 1'b0;
    qReady    = 1'b1;
    drain();
    chk("rand_sent", sent, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
